// File: rtl/fpu_pkg.sv
// fpu_pkg: constants and helpers shared by the FPU datapath blocks.
package fpu_pkg;

  // Native FPU word: IEEE-754 single precision.
  localparam int FPU_WORD_WIDTH = 32;

  // Bits needed to hold an occupancy value in 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_register_stage.sv
// pipe_stage: one pipeline slot (valid bit + data word).
// Data reset/flush clearing is controlled by PIPE_REGISTER_DATA_RST_EN;
// without it the data word is a plain load-enabled register with no reset.
module pipe_stage
  import fpu_pkg::*;
#(
  parameter int WIDTH = FPU_WORD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] d,
  output logic             valid,
  output logic [WIDTH-1:0] q
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  // Occupancy: flush wins, a load refills the slot, an unload empties it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
    end else if (unload) begin
      valid_reg <= 1'b0;
    end
  end

`ifdef PIPE_REGISTER_DATA_RST_EN
  // Data word with reset and flush clearing, so an empty pipe shows zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_reg <= '0;
    end else if (flush) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= d;
    end
  end
`else
  // Data word without reset; its content only matters while valid is set.
  always_ff @(posedge clk) begin
    if (load) begin
      data_reg <= d;
    end
  end
`endif

  assign valid = valid_reg;
  assign q     = data_reg;

endmodule

// File: rtl/pipe_register.sv
// pipe_register: DEPTH-stage valid/ready pipeline with bubble collapse,
// synchronous flush and occupancy count. The ready path is purely
// combinational from out_ready back to in_ready.
// Optional build macro: PIPE_REGISTER_DATA_RST_EN (reset/flush data words).
module pipe_register
  import fpu_pkg::*;
#(
  parameter int WIDTH = FPU_WORD_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [cnt_width(DEPTH)-1:0] count
);

  localparam int CW = cnt_width(DEPTH);

  logic             stage_valid [DEPTH];
  logic [WIDTH-1:0] stage_data  [DEPTH];
  logic [WIDTH-1:0] src_data    [DEPTH];
  logic [DEPTH-1:0] advance;
  logic [DEPTH-1:0] leave;
  logic [DEPTH-1:0] load;
  logic             accept;
  logic             handshake;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;

  // Ready chain, walked from the output backwards: a stage may advance when
  // it is empty or when its own item moves on this cycle.
  always_comb begin
    logic downstream;
    advance    = '0;
    leave      = '0;
    downstream = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      leave[i]   = stage_valid[i] && downstream;
      advance[i] = !stage_valid[i] || downstream;
      downstream = advance[i];
    end
  end

  assign in_ready  = !flush && advance[0];
  assign accept    = in_valid && in_ready;
  assign out_valid = stage_valid[DEPTH-1];
  assign out_data  = stage_data[DEPTH-1];
  assign handshake = out_valid && out_ready;

  // A stage loads only when its source holds an item and the stage advances.
  always_comb begin
    load    = '0;
    load[0] = accept;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = stage_valid[i-1] && advance[i];
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_src_in
        assign src_data[gi] = in_data;
      end else begin : g_src_prev
        assign src_data[gi] = stage_data[gi-1];
      end

      pipe_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .load   (load[gi]),
        .unload (leave[gi]),
        .d      (src_data[gi]),
        .valid  (stage_valid[gi]),
        .q      (stage_data[gi])
      );
    end
  endgenerate

  // Occupancy: +1 on accept alone, -1 on handshake alone, cleared by flush.
  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else if (accept && !handshake && count_reg != CW'(DEPTH)) begin
      count_next = count_reg + 1'b1;
    end else if (handshake && !accept && count_reg != '0) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Occupancy register, cleared asynchronously with the valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: tb/tb_pipe_register.sv
// tb_pipe_register: drives a DEPTH=2 and a DEPTH=4 pipe_register with the
// same stimulus and checks both against a queue-of-items reference model,
// plus directed table vectors and hand-written corner sequences.
module tb_pipe_register;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        fl;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_od;
    int          e_cnt;
  } vec_t;

  localparam logic [31:0] VA = 32'h3F800000;
  localparam logic [31:0] VB = 32'h40000000;
  localparam logic [31:0] VC = 32'h40400000;
  localparam logic [31:0] VD = 32'h40800000;
  localparam logic [31:0] VX = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;
  logic        ir0, ov0, ir1, ov1;
  logic [31:0] od0, od1;
  logic [1:0]  cnt0;
  logic [2:0]  cnt1;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: per instance, an ordered list of items (oldest first),
  // each with the stage index it currently sits in.
  int          mdep [2];
  int          m_n  [2];
  logic [31:0] m_d  [2][16];
  int          m_s  [2][16];

  vec_t tbl [21];
  vec_t nov;

  always #5 clk = ~clk;

  pipe_register #(.WIDTH(32), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .count(cnt0)
  );

  pipe_register #(.WIDTH(32), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .count(cnt1)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endfunction

  function automatic vec_t mk(logic iv, logic [31:0] d, logic ordy, logic fl,
                              logic eir, logic eov, logic [31:0] eod, int ecnt);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
    v.e_ir = eir; v.e_ov = eov; v.e_od = eod; v.e_cnt = ecnt;
    return v;
  endfunction

  // Advance the model by one clock edge.
  function automatic void m_step(int k, bit acc, bit hs, bit fl, logic [31:0] d);
    int lim;
    if (hs && k == 0) $display("xfer depth2 out 0x%08h", m_d[0][0]);
    if (fl) begin
      m_n[k] = 0;
      return;
    end
    if (hs) begin
      for (int j = 1; j < m_n[k]; j++) begin
        m_d[k][j-1] = m_d[k][j];
        m_s[k][j-1] = m_s[k][j];
      end
      m_n[k]--;
    end
    for (int j = 0; j < m_n[k]; j++) begin
      lim = (j == 0) ? mdep[k] - 1 : m_s[k][j-1] - 1;
      m_s[k][j] = (m_s[k][j] + 1 > lim) ? lim : m_s[k][j] + 1;
    end
    if (acc) begin
      m_d[k][m_n[k]] = d;
      m_s[k][m_n[k]] = 0;
      m_n[k]++;
    end
  endfunction

  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy,
                       input logic fl, input bit use_tv, input vec_t tv);
    bit acc [2];
    bit hs  [2];
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    if (use_tv) begin
      chk("tv_in_ready", 32'(ir0), 32'(tv.e_ir));
      chk("tv_out_valid", 32'(ov0), 32'(tv.e_ov));
      if (tv.e_ov) chk("tv_out_data", od0, tv.e_od);
      chk("tv_count", 32'(cnt0), 32'(tv.e_cnt));
    end
    for (int k = 0; k < 2; k++) begin
      logic        e_ir, e_ov, a_ir, a_ov;
      logic [31:0] a_od, a_cnt;
      e_ir = !fl && (m_n[k] < mdep[k] || ordy);
      e_ov = (m_n[k] > 0) && (m_s[k][0] == mdep[k] - 1);
      a_ir = (k == 0) ? ir0 : ir1;
      a_ov = (k == 0) ? ov0 : ov1;
      a_od = (k == 0) ? od0 : od1;
      a_cnt = (k == 0) ? 32'(cnt0) : 32'(cnt1);
      chk((k == 0) ? "m2_in_ready" : "m4_in_ready", 32'(a_ir), 32'(e_ir));
      chk((k == 0) ? "m2_out_valid" : "m4_out_valid", 32'(a_ov), 32'(e_ov));
      if (e_ov) chk((k == 0) ? "m2_out_data" : "m4_out_data", a_od, m_d[k][0]);
      chk((k == 0) ? "m2_count" : "m4_count", a_cnt, 32'(m_n[k]));
      acc[k] = iv && e_ir;
      hs[k]  = e_ov && ordy;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) m_step(k, acc[k], hs[k], fl, d);
  endtask

  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    cycle(iv, d, ordy, fl, 1'b0, nov);
  endtask

  initial begin
    nov = mk(0, 0, 0, 0, 0, 0, 0, 0);
    mdep[0] = 2; mdep[1] = 4;
    m_n[0] = 0;  m_n[1] = 0;

    // streaming, out_ready held high
    tbl[0]  = mk(1, VA, 1, 0, 1, 0, 0,  0);
    tbl[1]  = mk(1, VB, 1, 0, 1, 0, 0,  1);
    tbl[2]  = mk(1, VC, 1, 0, 1, 1, VA, 2);
    tbl[3]  = mk(0, 0,  1, 0, 1, 1, VB, 2);
    tbl[4]  = mk(0, 0,  1, 0, 1, 1, VC, 1);
    tbl[5]  = mk(0, 0,  1, 0, 1, 0, 0,  0);
    // back-pressure, release, then accept + handshake at count 1
    tbl[6]  = mk(1, VA, 0, 0, 1, 0, 0,  0);
    tbl[7]  = mk(1, VB, 0, 0, 1, 0, 0,  1);
    tbl[8]  = mk(1, VC, 0, 0, 0, 1, VA, 2);
    tbl[9]  = mk(1, VC, 0, 0, 0, 1, VA, 2);
    tbl[10] = mk(1, VC, 1, 0, 1, 1, VA, 2);
    tbl[11] = mk(0, 0,  1, 0, 1, 1, VB, 2);
    tbl[12] = mk(1, VD, 1, 0, 1, 1, VC, 1);
    tbl[13] = mk(0, 0,  1, 0, 1, 0, 0,  1);
    tbl[14] = mk(0, 0,  1, 0, 1, 1, VD, 1);
    tbl[15] = mk(0, 0,  1, 0, 1, 0, 0,  0);
    // flush with the pipe full and an input offered
    tbl[16] = mk(1, VA, 0, 0, 1, 0, 0,  0);
    tbl[17] = mk(1, VB, 0, 0, 1, 0, 0,  1);
    tbl[18] = mk(1, VX, 0, 1, 0, 1, VA, 2);
    tbl[19] = mk(0, 0,  0, 0, 1, 0, 0,  0);
    tbl[20] = mk(0, 0,  1, 0, 1, 0, 0,  0);

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready2", 32'(ir0), 32'd1);
    chk("rst_out_valid2", 32'(ov0), 32'd0);
    chk("rst_count2", 32'(cnt0), 32'd0);
    chk("rst_in_ready4", 32'(ir1), 32'd1);
    chk("rst_out_valid4", 32'(ov1), 32'd0);
    chk("rst_count4", 32'(cnt1), 32'd0);
`ifdef PIPE_REGISTER_DATA_RST_EN
    chk("rst_out_data2", od0, 32'd0);
`endif
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 21; i++) begin
      cycle(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, 1'b1, tbl[i]);
    end

    // bubble collapse in the 4-deep pipe while the output is stalled
    step(1, VA, 0, 0); chk("bub_ov_e1", 32'(ov1), 32'd0);
    step(0, 0, 0, 0);  chk("bub_ov_e2", 32'(ov1), 32'd0);
    step(0, 0, 0, 0);  chk("bub_ov_e3", 32'(ov1), 32'd0);
    step(0, 0, 0, 0);  chk("bub_ov_e4", 32'(ov1), 32'd1);
    chk("bub_od_e4", od1, VA);
    step(1, VB, 0, 0); chk("bub_cnt", 32'(cnt1), 32'd2);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("bub_cnt_hold", 32'(cnt1), 32'd2);
    chk("bub_ov_hold", 32'(ov1), 32'd1);
    chk("bub_od_hold", od1, VA);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);

    // randomized traffic with occasional flush
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0);
    end

    // asynchronous reset between edges, mid-stream
    step(1, 32'h11111111, 1, 0);
    step(1, 32'h22222222, 1, 0);
    step(1, 32'h33333333, 1, 0);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst_out_valid2", 32'(ov0), 32'd0);
    chk("arst_count2", 32'(cnt0), 32'd0);
    chk("arst_out_valid4", 32'(ov1), 32'd0);
    chk("arst_count4", 32'(cnt1), 32'd0);
`ifdef PIPE_REGISTER_DATA_RST_EN
    chk("arst_out_data2", od0, 32'd0);
    chk("arst_out_data4", od1, 32'd0);
`endif
    m_n[0] = 0; m_n[1] = 0;
    #1 rst = 1'b1;
    step(1, 32'h5A5A5A5A, 1, 0); chk("lat_ov2_e1", 32'(ov0), 32'd0);
    step(0, 0, 1, 0);            chk("lat_ov2_e2", 32'(ov0), 32'd1);
    chk("lat_od2_e2", od0, 32'h5A5A5A5A);
    step(0, 0, 1, 0);            chk("lat_ov4_e3", 32'(ov1), 32'd0);
    step(0, 0, 1, 0);            chk("lat_ov4_e4", 32'(ov1), 32'd1);
    chk("lat_od4_e4", od1, 32'h5A5A5A5A);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_register.md
# pipe_register

Parametrised multi-stage pipeline register with per-stage valid/ready flow control, synchronous flush and an occupancy counter. It is the general successor to the single load-enabled register: FPU datapaths (adder, multiplier, divider stages) insert it between combinational stages to add DEPTH cycles of latency. It stalls cleanly under back-pressure and collapses bubbles so throughput stays at one item per cycle.

## Interface
- WIDTH, 32, data bits per stage
- DEPTH, 2, number of register stages (legal range 1..16)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- flush  input  1  synchronous; discards all stored items
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  block accepts in_data this cycle
- in_data  input  WIDTH  incoming item
- out_valid  output  1  last stage holds an item
- out_ready  input  1  downstream accepts out_data
- out_data  output  WIDTH  item in last stage
- count  output  $clog2(DEPTH+1)  number of valid items stored

## Operation
- Stages 0..DEPTH-1; stage 0 is fed by the input, stage DEPTH-1 drives the outputs. Each stage holds a valid bit and a WIDTH data word.
- Stage i advances (takes from stage i-1 or the input) when it is empty, or when it is full and its own item leaves this cycle. For the last stage, "leaves" means out_valid && out_ready.
- Stage i loads only when its source is valid and it advances. Otherwise it holds data and valid unchanged, which gives bubble collapse: empty stages fill even while the output is stalled.
- in_ready = !flush && (stage 0 empty || stage 0 advancing). in_ready depends combinationally on out_ready through the ready chain. There is no register on the ready path.
- Input accept = in_valid && in_ready. Output handshake = out_valid && out_ready.
- count update rules:
  - +1 on accept only.
  - -1 on handshake only.
  - Unchanged when both occur.
  - Never exceeds DEPTH and never underflows.
- flush:
  - At the next edge all valid bits clear and count becomes 0.
  - An input offered in a flush cycle is not accepted, because in_ready is 0.
  - An output handshake in a flush cycle still completes: downstream sees the item once.
- Reset (rst = 0, at any time, including mid-transfer): all valid bits clear and count = 0 immediately and asynchronously. Items in flight are lost.
- Reset values: out_valid = 0, count = 0, in_ready = 1 (given flush = 0), out_data per Configuration.
- Data ordering is strictly FIFO. Items are never duplicated or reordered.

## Timing
- Latency: an item accepted at edge N appears with out_valid = 1 after edge N+DEPTH-1, i.e. DEPTH cycles input-to-output, when never stalled.
- Throughput: 1 item/cycle with out_ready held at 1.
- Stall: while out_valid && !out_ready, out_data and out_valid are held stable.
- Full pipeline under a stall: count = DEPTH and in_ready = 0. The cycle out_ready rises, in_ready = 1 combinationally.
- DEPTH = 1: in_ready = !flush && (!out_valid || out_ready).

## Configuration
- PIPE_REGISTER_DATA_RST_EN defined:
  - Every stage data word resets to 0.
  - Data words are also zeroed on flush.
  - out_data = 0 after reset.
- PIPE_REGISTER_DATA_RST_EN undefined:
  - Only valid bits and count are reset or flushed.
  - Data words have no reset, so synthesis can map them to reset-free flops.
  - out_data is don't-care whenever out_valid = 0.
- Handshake, latency and count behaviour are identical in both builds.

## Structure
- Shared package fpu_pkg holds:
  - FPU_WORD_WIDTH = 32, used as the WIDTH default.
  - A count-width helper function equivalent to $clog2(DEPTH+1).
- Sub-module pipe_stage: one valid bit plus one data word, with load/flush inputs and the data-reset macro handling. pipe_register instantiates DEPTH of them via generate and owns the ready chain and count.

## Test plan
- Streaming, DEPTH=2, WIDTH=32, out_ready=1, inputs 0x3F800000, 0x40000000, 0x40400000 on consecutive cycles -> same values out in order, first one 2 cycles after accept, one per cycle, count peaks at 2.
- Back-pressure with out_ready=0 while feeding 3 items -> count reaches 2, in_ready=0, out_data holds 0x3F800000. Then out_ready=1 -> third item accepted the same cycle, order preserved.
- Bubble collapse, DEPTH=4: one item accepted, out_ready=0 -> it reaches the last stage after 4 cycles. A second item fills stage 2 while the first is held, count = 2.
- Flush with pipeline full and in_valid=1, in_data=0xDEADBEEF -> in_ready=0 that cycle, out_valid=0 and count=0 next cycle, 0xDEADBEEF never appears at the output.
- Async reset asserted mid-stream between clock edges -> out_valid=0 and count=0 immediately. With PIPE_REGISTER_DATA_RST_EN, out_data=0. After release, the next accepted item has a clean DEPTH-cycle latency.
- Simultaneous accept and output handshake at count=1 -> count stays 1 and both items are delivered in order.
